// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU: control-word bit
// positions, opcode values and sequencer state encodings. The datapath
// blocks use the same bit indices when they pick apart control_signal.
package cpu_pkg;

   // Control-word bit positions
   localparam int CB_PC_INC       = 0;
   localparam int CB_PC_LOAD      = 1;
   localparam int CB_MAR_FROM_PC  = 2;
   localparam int CB_MAR_FROM_MBR = 3;
   localparam int CB_MEM_RD       = 4;
   localparam int CB_MEM_WR       = 5;
   localparam int CB_MBR_FROM_MEM = 6;
   localparam int CB_MBR_FROM_ACC = 7;
   localparam int CB_IR_LOAD      = 8;
   localparam int CB_ALU_ADD      = 9;
   localparam int CB_ALU_SUB      = 10;
   localparam int CB_ACC_LOAD_ALU = 11;
   localparam int CB_ACC_LOAD_MBR = 12;
   localparam int CB_ACC_CLR      = 21;

   // Opcodes; anything above OP_HALT is undefined
   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_LOAD   = 8'h01;
   localparam logic [7:0] OP_STORE  = 8'h02;
   localparam logic [7:0] OP_ADD    = 8'h03;
   localparam logic [7:0] OP_SUB    = 8'h04;
   localparam logic [7:0] OP_JMP    = 8'h05;
   localparam logic [7:0] OP_JMPGEZ = 8'h06;
   localparam logic [7:0] OP_HALT   = 8'h07;

   // Sequencer state encodings (visible on state_out)
   localparam logic [2:0] S_INIT = 3'd0;
   localparam logic [2:0] S_F1   = 3'd1;
   localparam logic [2:0] S_F2   = 3'd2;
   localparam logic [2:0] S_F3   = 3'd3;
   localparam logic [2:0] S_D1   = 3'd4;
   localparam logic [2:0] S_E1   = 3'd5;
   localparam logic [2:0] S_E2   = 3'd6;
   localparam logic [2:0] S_HALT = 3'd7;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decode: maps the sequencer state, the latched
// opcode and (in D1 and the memory wait states) the live inputs onto the
// control bits. Only bits named in cpu_pkg are ever driven.
module ctrl_decode
   import cpu_pkg::*;
#(
   parameter int OPC_W = 8,
   parameter int CW_W  = 32
) (
   input  logic [2:0]       state,
   input  logic [OPC_W-1:0] op_q,
   input  logic [OPC_W-1:0] ir_opcode,
   input  logic             mem_ready,
   input  logic             acc_neg,
   output logic [CW_W-1:0]  control_word
);

   logic [CW_W-1:0] cw_s;

   // Decode the state (and, where relevant, opcode/handshake) into control bits
   always_comb begin
      cw_s = '0;
      case (state)
         S_INIT: cw_s[CB_ACC_CLR] = 1'b1;
         S_F1:   cw_s[CB_MAR_FROM_PC] = 1'b1;
         S_F2: begin
            cw_s[CB_MEM_RD]       = 1'b1;
            cw_s[CB_MBR_FROM_MEM] = 1'b1;
            // PC advances only on the cycle the fetch read completes
            if (mem_ready) begin
               cw_s[CB_PC_INC] = 1'b1;
            end else begin
               cw_s[CB_PC_INC] = 1'b0;
            end
         end
         S_F3:   cw_s[CB_IR_LOAD] = 1'b1;
         S_D1: begin
            cw_s[CB_MAR_FROM_MBR] = 1'b1;
            // op_q is not yet valid in D1, so jumps decode the live IR field
            if (ir_opcode == OPC_W'(OP_JMP)) begin
               cw_s[CB_PC_LOAD] = 1'b1;
            end else if ((ir_opcode == OPC_W'(OP_JMPGEZ)) && !acc_neg) begin
               cw_s[CB_PC_LOAD] = 1'b1;
            end else begin
               cw_s[CB_PC_LOAD] = 1'b0;
            end
         end
         S_E1: begin
            if ((op_q == OPC_W'(OP_LOAD)) || (op_q == OPC_W'(OP_ADD)) ||
                (op_q == OPC_W'(OP_SUB))) begin
               cw_s[CB_MEM_RD]       = 1'b1;
               cw_s[CB_MBR_FROM_MEM] = 1'b1;
            end else if (op_q == OPC_W'(OP_STORE)) begin
               cw_s[CB_MBR_FROM_ACC] = 1'b1;
            end else begin
               cw_s = '0;
            end
         end
         S_E2: begin
            if (op_q == OPC_W'(OP_LOAD)) begin
               cw_s[CB_ACC_LOAD_MBR] = 1'b1;
            end else if (op_q == OPC_W'(OP_ADD)) begin
               cw_s[CB_ALU_ADD]      = 1'b1;
               cw_s[CB_ACC_LOAD_ALU] = 1'b1;
            end else if (op_q == OPC_W'(OP_SUB)) begin
               cw_s[CB_ALU_SUB]      = 1'b1;
               cw_s[CB_ACC_LOAD_ALU] = 1'b1;
            end else if (op_q == OPC_W'(OP_STORE)) begin
               cw_s[CB_MEM_WR] = 1'b1;
            end else begin
               cw_s = '0;
            end
         end
         S_HALT:  cw_s = '0;
         default: cw_s = '0;
      endcase
   end

   assign control_word = cw_s;

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the accumulator CPU. Holds
// the state register, the opcode latched in D1 and the sticky illegal flag;
// the control word itself comes from ctrl_decode.
module ctrl_sequencer
   import cpu_pkg::*;
#(
   parameter int OPC_W = 8,
   parameter int CW_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OPC_W-1:0] ir_opcode,
   input  logic             acc_neg,
   input  logic             mem_ready,
   output logic [CW_W-1:0]  control_signal,
   output logic             halted,
   output logic             illegal,
   output logic [2:0]       state_out
);

   logic [2:0]       state_r;
   logic [2:0]       state_nxt_s;
   logic [OPC_W-1:0] op_q_r;
   logic             illegal_r;
   logic             opc_legal_s;
   logic             exec_op_s;

   // Opcode classification on the live IR field, used only in D1
   always_comb begin
      opc_legal_s = (ir_opcode <= OPC_W'(OP_HALT));
      exec_op_s   = (ir_opcode == OPC_W'(OP_LOAD))  ||
                    (ir_opcode == OPC_W'(OP_STORE)) ||
                    (ir_opcode == OPC_W'(OP_ADD))   ||
                    (ir_opcode == OPC_W'(OP_SUB));
   end

   // Next-state selection, including memory wait holds
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_INIT: state_nxt_s = S_F1;
         S_F1:   state_nxt_s = S_F2;
         S_F2: begin
            if (mem_ready) begin
               state_nxt_s = S_F3;
            end else begin
               state_nxt_s = S_F2;
            end
         end
         S_F3:   state_nxt_s = S_D1;
         S_D1: begin
            if (ir_opcode == OPC_W'(OP_HALT)) begin
               state_nxt_s = S_HALT;
            end else if (exec_op_s) begin
               state_nxt_s = S_E1;
            end else begin
               // NOP, jumps and illegal opcodes all finish here
               state_nxt_s = S_F1;
            end
         end
         S_E1: begin
            // STORE only moves ACC into MBR here; reads wait for memory
            if (op_q_r == OPC_W'(OP_STORE)) begin
               state_nxt_s = S_E2;
            end else if (mem_ready) begin
               state_nxt_s = S_E2;
            end else begin
               state_nxt_s = S_E1;
            end
         end
         S_E2: begin
            if ((op_q_r == OPC_W'(OP_STORE)) && !mem_ready) begin
               state_nxt_s = S_E2;
            end else begin
               state_nxt_s = S_F1;
            end
         end
         S_HALT:  state_nxt_s = S_HALT;
         default: state_nxt_s = S_INIT;
      endcase
   end

   // State register; reset abandons any partial instruction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_INIT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Opcode latch and sticky illegal flag, both updated in D1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q_r    <= '0;
         illegal_r <= 1'b0;
      end else if (state_r == S_D1) begin
         op_q_r <= ir_opcode;
         if (!opc_legal_s) begin
            illegal_r <= 1'b1;
         end
      end
   end

   ctrl_decode #(
      .OPC_W (OPC_W),
      .CW_W  (CW_W)
   ) u_decode (
      .state        (state_r),
      .op_q         (op_q_r),
      .ir_opcode    (ir_opcode),
      .mem_ready    (mem_ready),
      .acc_neg      (acc_neg),
      .control_word (control_signal)
   );

   assign halted    = (state_r == S_HALT);
   assign illegal   = illegal_r;
   assign state_out = state_r;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: reset checks, a table of
// instruction vectors with hand-written expectations, randomized
// instruction streams against a cycle-list reference model, and hand
// sequences for reset during a wait state and during HALT.
module tb_ctrl_sequencer;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  ir_opcode;
   logic        acc_neg;
   logic        mem_ready;
   logic [31:0] control_signal;
   logic        halted;
   logic        illegal;
   logic [2:0]  state_out;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic ill_exp;

   typedef struct {
      logic        mr;
      logic        an;
      logic [31:0] word;
   } cyc_t;

   typedef struct {
      logic [7:0]  op;
      logic        an;
      int          wf;
      int          we;
      int          len;
      logic [31:0] d1;
      logic [31:0] last;
      int          wr;
   } vec_t;

   cyc_t trace_q[$];
   vec_t vecs[11];

   ctrl_sequencer #(.OPC_W(8), .CW_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .ir_opcode      (ir_opcode),
      .acc_neg        (acc_neg),
      .mem_ready      (mem_ready),
      .control_signal (control_signal),
      .halted         (halted),
      .illegal        (illegal),
      .state_out      (state_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Reference model: the expected per-cycle list of (mem_ready to drive,
   // acc_neg to drive, control word) for one whole instruction.
   task automatic build_trace(input logic [7:0] op, input logic an, input int wf, input int we);
      logic [31:0] d1;
      logic [31:0] e2;
      trace_q.delete();
      trace_q.push_back('{rbit(), rbit(), 32'h0000_0004});
      for (int i = 0; i < wf; i++) trace_q.push_back('{1'b0, rbit(), 32'h0000_0050});
      trace_q.push_back('{1'b1, rbit(), 32'h0000_0051});
      trace_q.push_back('{rbit(), rbit(), 32'h0000_0100});
      d1 = 32'h0000_0008;
      if (op == OP_JMP || (op == OP_JMPGEZ && !an)) d1 = d1 | 32'h0000_0002;
      trace_q.push_back('{rbit(), an, d1});
      if (op == OP_LOAD || op == OP_ADD || op == OP_SUB) begin
         for (int i = 0; i < we; i++) trace_q.push_back('{1'b0, rbit(), 32'h0000_0050});
         trace_q.push_back('{1'b1, rbit(), 32'h0000_0050});
         e2 = (op == OP_LOAD) ? 32'h0000_1000 : (op == OP_ADD) ? 32'h0000_0A00 : 32'h0000_0C00;
         trace_q.push_back('{rbit(), rbit(), e2});
      end else if (op == OP_STORE) begin
         trace_q.push_back('{rbit(), rbit(), 32'h0000_0080});
         for (int i = 0; i < we; i++) trace_q.push_back('{1'b0, rbit(), 32'h0000_0020});
         trace_q.push_back('{1'b1, rbit(), 32'h0000_0020});
      end
   endtask

   // Runs one instruction starting at posedge+1 in S_F1; returns at
   // posedge+1 once the DUT is back in S_F1 (or after the trace if stop_end).
   task automatic run_instr(input logic [7:0] op, input logic an, input int wf, input int we,
                            input bit stop_end, output int len, output logic [31:0] d1w,
                            output logic [31:0] lastw, output int wr_cnt);
      int c;
      int d1_idx;
      logic [31:0] expw;
      build_trace(op, an, wf, we);
      d1_idx = 3 + wf;
      wr_cnt = 0;
      d1w    = '0;
      lastw  = '0;
      c      = 0;
      while (1) begin
         if (c > 0 && state_out == S_F1) break;
         if (stop_end && c == trace_q.size()) break;
         if (c >= 40) begin
            chk("instr_timeout", 32'(c), 32'(trace_q.size()));
            break;
         end
         if (c < trace_q.size()) begin
            mem_ready = trace_q[c].mr;
            acc_neg   = trace_q[c].an;
            expw      = trace_q[c].word;
         end else begin
            mem_ready = 1'b1;
            acc_neg   = 1'b0;
            expw      = 32'hFFFF_FFFF;
         end
         ir_opcode = op;
         @(negedge clk);
         chk($sformatf("cw op%0h c%0d", op, c), control_signal, expw);
         chk("illegal_hold", 32'(illegal), 32'(ill_exp));
         chk("rd_wr_excl", 32'(control_signal[4] & control_signal[5]), 32'h0);
         if (c == d1_idx) d1w = control_signal;
         lastw = control_signal;
         if (control_signal[5]) wr_cnt++;
         @(posedge clk);
         #1;
         c++;
      end
      len = c;
      if (op > OP_HALT) ill_exp = 1'b1;
      chk("illegal_sticky", 32'(illegal), 32'(ill_exp));
   endtask

   initial begin
      int len;
      int wr;
      int r;
      logic [31:0] d1w;
      logic [31:0] lastw;
      logic [7:0]  op;

      vecs[0]  = '{OP_LOAD,   1'b0, 0, 0, 6, 32'h8, 32'h1000, 0};
      vecs[1]  = '{OP_ADD,    1'b1, 0, 0, 6, 32'h8, 32'h0A00, 0};
      vecs[2]  = '{OP_SUB,    1'b0, 1, 2, 9, 32'h8, 32'h0C00, 0};
      vecs[3]  = '{OP_STORE,  1'b0, 0, 3, 9, 32'h8, 32'h0020, 4};
      vecs[4]  = '{OP_STORE,  1'b1, 2, 0, 8, 32'h8, 32'h0020, 1};
      vecs[5]  = '{OP_NOP,    1'b0, 0, 0, 4, 32'h8, 32'h0008, 0};
      vecs[6]  = '{OP_JMP,    1'b1, 0, 0, 4, 32'hA, 32'h000A, 0};
      vecs[7]  = '{OP_JMPGEZ, 1'b1, 0, 0, 4, 32'h8, 32'h0008, 0};
      vecs[8]  = '{OP_JMPGEZ, 1'b0, 1, 0, 5, 32'hA, 32'h000A, 0};
      vecs[9]  = '{8'hFF,     1'b0, 0, 0, 4, 32'h8, 32'h0008, 0};
      vecs[10] = '{8'h08,     1'b1, 0, 0, 4, 32'h8, 32'h0008, 0};

      rst = 1'b1; mem_ready = 1'b0; acc_neg = 1'b0; ir_opcode = 8'h00; ill_exp = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", 32'(state_out), 32'(S_INIT));
      chk("rst_cw", control_signal, 32'h0020_0000);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_illegal", 32'(illegal), 32'h0);

      // Release: one S_INIT cycle, then S_F1
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("init_cw", control_signal, 32'h0020_0000);
      @(posedge clk);
      #1;
      chk("f1_state", 32'(state_out), 32'(S_F1));
      chk("f1_cw", control_signal, 32'h0000_0004);

      // Table-driven instruction vectors
      for (int i = 0; i < 11; i++) begin
         run_instr(vecs[i].op, vecs[i].an, vecs[i].wf, vecs[i].we, 1'b0, len, d1w, lastw, wr);
         chk($sformatf("vec%0d_len", i), 32'(len), 32'(vecs[i].len));
         chk($sformatf("vec%0d_d1", i), d1w, vecs[i].d1);
         chk($sformatf("vec%0d_last", i), lastw, vecs[i].last);
         chk($sformatf("vec%0d_wr", i), 32'(wr), 32'(vecs[i].wr));
      end

      // Randomized instruction stream against the model
      for (int i = 0; i < 40; i++) begin
         r  = $urandom_range(0, 7);
         op = (r < 7) ? 8'(r) : 8'($urandom_range(8, 255));
         run_instr(op, rbit(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, len, d1w, lastw, wr);
         chk($sformatf("rnd%0d_len", i), 32'(len), 32'(trace_q.size()));
      end

      // Reset in the middle of an S_F2 wait
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("f2wait_state", 32'(state_out), 32'(S_F2));
      chk("f2wait_cw", control_signal, 32'h0000_0050);
      @(posedge clk);
      #1;
      chk("f2wait_hold", 32'(state_out), 32'(S_F2));
      rst = 1'b1;
      #1;
      ill_exp = 1'b0;
      chk("f2rst_state", 32'(state_out), 32'(S_INIT));
      chk("f2rst_illegal", 32'(illegal), 32'h0);
      chk("f2rst_cw", control_signal, 32'h0020_0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("f2rst_f1", 32'(state_out), 32'(S_F1));

      // Illegal opcode then HALT
      run_instr(8'hFF, 1'b0, 0, 0, 1'b0, len, d1w, lastw, wr);
      chk("ill_len", 32'(len), 32'd4);
      run_instr(OP_HALT, 1'b0, 0, 0, 1'b1, len, d1w, lastw, wr);
      chk("halt_state", 32'(state_out), 32'(S_HALT));
      chk("halt_halted", 32'(halted), 32'h1);
      chk("halt_cw", control_signal, 32'h0);
      chk("halt_illegal", 32'(illegal), 32'h1);
      mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("halt_stays", 32'(state_out), 32'(S_HALT));
      chk("halt_cw_stays", control_signal, 32'h0);

      // Reset while halted
      rst = 1'b1;
      #1;
      ill_exp = 1'b0;
      chk("hrst_state", 32'(state_out), 32'(S_INIT));
      chk("hrst_halted", 32'(halted), 32'h0);
      chk("hrst_illegal", 32'(illegal), 32'h0);
      chk("hrst_cw", control_signal, 32'h0020_0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("hrst_f1", 32'(state_out), 32'(S_F1));
      run_instr(OP_LOAD, 1'b0, 1, 1, 1'b0, len, d1w, lastw, wr);
      chk("post_load_len", 32'(len), 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
